rf_write_queue: RTL and testbench

//   Write-back buffer directly upstream of the 3-port register file write port (we3/wa3/wd3).

---
 rtl/rf_write_queue.sv | 126 ++++++++++++
 tb/tb_rf_write_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_queue.sv
// Write-back queue feeding the register-file write port, with read bypass and a pending-register mask.
// Optional feature: define RFQ_COALESCE_EN to merge a write into the tail entry when it targets the same register.
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     wb_stall,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [DW-1:0]            wd3,
  input  logic [AW-1:0]            byp_ra1,
  input  logic [AW-1:0]            byp_ra2,
  output logic                     byp_hit1,
  output logic [DW-1:0]            byp_data1,
  output logic                     byp_hit2,
  output logic [DW-1:0]            byp_data2,
  output logic [(2**AW)-1:0]       pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q, tail_q, last_idx, idx;
  logic [PW:0]      cnt_q;
  logic             empty, full, pop, nz, tail_match, coal, accept, alloc;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CNT_FULL);
  assign last_idx   = tail_q - PTR_ONE;
  assign nz         = (in_addr != '0);
  assign tail_match = !empty && nz && (addr_q[last_idx] == in_addr);
  assign pop        = !empty && !wb_stall;

`ifdef RFQ_COALESCE_EN
  // When full the tail is never the head (DEPTH >= 2), so in_ready stays free of wb_stall.
  assign in_ready = !full || tail_match;
  assign coal     = in_valid && tail_match && !((cnt_q == CNT_ONE) && pop);
`else
  assign in_ready = !full;
  assign coal     = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign alloc  = accept && nz && !coal;

  assign we3   = pop;
  assign wa3   = empty ? '0 : addr_q[head_q];
  assign wd3   = empty ? '0 : data_q[head_q];
  assign count = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_ONE;
      end
      if (alloc) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_ONE;
      end
      case ({alloc, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage carries no reset; it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
    if (coal) begin
      data_q[last_idx] <= in_data;
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    idx       = '0;
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (vld_q[idx] && (byp_ra1 != '0) && (addr_q[idx] == byp_ra1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = data_q[idx];
      end
      if (vld_q[idx] && (byp_ra2 != '0) && (addr_q[idx] == byp_ra2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = data_q[idx];
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pending[addr_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_write_queue.sv
// Scoreboard bench for rf_write_queue: stimulus pushes expected writes, a negedge monitor checks drains.
`timescale 1ns/1ps
module tb_rf_write_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [AW-1:0]     in_addr = '0;
  logic [DW-1:0]     in_data = '0;
  logic              wb_stall = 1'b0;
  logic              we3;
  logic [AW-1:0]     wa3;
  logic [DW-1:0]     wd3;
  logic [AW-1:0]     byp_ra1 = '0;
  logic [AW-1:0]     byp_ra2 = '0;
  logic              byp_hit1, byp_hit2;
  logic [DW-1:0]     byp_data1, byp_data2;
  logic [(2**AW)-1:0] pending;
  logic [CW-1:0]     count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t exp_q[$];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rf_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_stall(wb_stall), .we3(we3), .wa3(wa3), .wd3(wd3),
    .byp_ra1(byp_ra1), .byp_ra2(byp_ra2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .pending(pending), .count(count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every drain must match the oldest expected write, and a non-stalled nonempty queue must drain.
  always @(negedge clk) begin
    ent_t e;
    if (reset_n) begin
      chk("mon_count", 64'(count), 64'(exp_q.size()));
      if (we3) begin
        chk("mon_we3_while_stall", 64'(wb_stall), 0);
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_we3", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_wa3", 64'(wa3), 64'(e.a));
          chk("mon_wd3", 64'(wd3), 64'(e.d));
        end
      end else if (!wb_stall && exp_q.size() != 0) begin
        chk("mon_missing_drain", 0, 1);
      end
    end
  end

  // Holds the write until in_ready; the model is updated after the monitor's pop for that cycle.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    ent_t t;
    n = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("push_timeout", 0, 1);
    end else begin
      #1;
      if (a != '0) begin
        t.a = a;
        t.d = d;
`ifdef RFQ_COALESCE_EN
        if (exp_q.size() != 0 && exp_q[$].a == a) void'(exp_q.pop_back());
`endif
        exp_q.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 0);
    chk("drain_count", 64'(count), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset values
    #1;
    chk("rst_we3", 64'(we3), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_count", 64'(count), 0);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_hit1", 64'(byp_hit1), 0);
    chk("rst_hit2", 64'(byp_hit2), 0);
    chk("rst_wa3", 64'(wa3), 0);
    chk("rst_wd3", 64'(wd3), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Back-to-back writes drain on consecutive cycles in order
    push(5, 32'h11);
    push(6, 32'h22);
    push(7, 32'h33);
    drain();

    // Fill under stall, hold an extra write, then release
    wb_stall = 1'b1;
    push(1, 32'h101);
    push(2, 32'h202);
    push(3, 32'h303);
    push(4, 32'h404);
    chk("full_count", 64'(count), 4);
    chk("full_ready", 64'(in_ready), 0);
    chk("full_pending", 64'(pending), 64'h1E);
    in_valid = 1'b1;
    in_addr  = 8;
    in_data  = 32'h808;
    repeat (3) begin
      @(negedge clk);
      chk("held_count", 64'(count), 4);
      chk("held_ready", 64'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wb_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_pop", 64'(in_ready), 1);
    chk("count_after_pop", 64'(count), 3);
    drain();

    // Duplicate register: youngest data bypassed, pending held until the last copy leaves
    wb_stall = 1'b1;
    push(9, 32'hA);
    push(9, 32'hB);
    byp_ra1 = 9;
    byp_ra2 = 0;
    #1;
    chk("dup_hit1", 64'(byp_hit1), 1);
    chk("dup_data1", 64'(byp_data1), 32'hB);
    chk("dup_hit2_r0", 64'(byp_hit2), 0);
    chk("dup_data2_r0", 64'(byp_data2), 0);
    chk("dup_pending9", 64'(pending[9]), 1);
`ifdef RFQ_COALESCE_EN
    chk("dup_count", 64'(count), 1);
`else
    chk("dup_count", 64'(count), 2);
`endif
    byp_ra2 = 9;
    #1;
    chk("dup_hit2", 64'(byp_hit2), 1);
    chk("dup_data2", 64'(byp_data2), 32'hB);
    byp_ra2 = 0;
    wb_stall = 1'b0;
    @(posedge clk);
    #1;
    wb_stall = 1'b1;
`ifdef RFQ_COALESCE_EN
    chk("dup_pop1_pending9", 64'(pending[9]), 0);
    chk("dup_pop1_hit1", 64'(byp_hit1), 0);
`else
    chk("dup_pop1_pending9", 64'(pending[9]), 1);
    chk("dup_pop1_hit1", 64'(byp_hit1), 1);
    chk("dup_pop1_data1", 64'(byp_data1), 32'hB);
`endif
    wb_stall = 1'b0;
    drain();
    chk("dup_end_pending", 64'(pending), 0);
    chk("dup_end_hit1", 64'(byp_hit1), 0);
    chk("dup_end_data1", 64'(byp_data1), 0);
    byp_ra1 = 0;

    // Writes to r0 handshake but never allocate
    push(0, 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("r0_count", 64'(count), 0);
    chk("r0_pending", 64'(pending), 0);

    // Continuous push with concurrent pop wraps the pointers several times
    for (int i = 0; i < 10; i++) push(AW'(10 + i), 32'h1000 + 32'(i));
    drain();

`ifdef RFQ_COALESCE_EN
    // Same-register writes merge; a full queue still takes a write to its tail register
    wb_stall = 1'b1;
    push(3, 32'h1);
    push(3, 32'h2);
    chk("coal_count", 64'(count), 1);
    chk("coal_wa3", 64'(wa3), 3);
    chk("coal_wd3", 64'(wd3), 2);
    push(11, 32'hB1);
    push(12, 32'hC1);
    push(13, 32'hD1);
    in_addr = 12;
    #1;
    chk("coal_full_ready_other", 64'(in_ready), 0);
    in_addr = 13;
    #1;
    chk("coal_full_ready_tail", 64'(in_ready), 1);
    push(13, 32'h77);
    chk("coal_full_count", 64'(count), 4);
    wb_stall = 1'b0;
    drain();
`endif

    // Reset mid-stream discards queued writes immediately
    wb_stall = 1'b1;
    push(20, 32'h20);
    push(21, 32'h21);
    push(22, 32'h22);
    chk("pre_rst_count", 64'(count), 3);
    wb_stall = 1'b0;
    #1;
    chk("pre_rst_we3", 64'(we3), 1);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_we3", 64'(we3), 0);
    chk("mid_rst_count", 64'(count), 0);
    chk("mid_rst_pending", 64'(pending), 0);
    chk("mid_rst_ready", 64'(in_ready), 1);
    chk("mid_rst_wa3", 64'(wa3), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push(23, 32'h99);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
